// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with write-to-read bypass, a per-register busy scoreboard
// and a sequential clear engine that zeroes one entry per cycle after reset or on request.
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     sb_set_en,
   input  logic [ADDR_W-1:0]        sb_set_addr,
   input  logic                     clr_req,
   output logic                     clr_busy
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;
   localparam logic [ADDR_W-1:0] LAST_ENTRY = '1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              idle;
   logic              wr_to_zero;
   logic              set_to_zero;

   assign idle        = (state_q == ST_IDLE);
   assign clr_busy    = (state_q == ST_CLEAR);
   assign wr_to_zero  = (ZERO_REG != 0) && (wr_addr == '0);
   assign set_to_zero = (ZERO_REG != 0) && (sb_set_addr == '0);

   // The clear engine owns the single array write port while it runs, so normal
   // writeback, scoreboard updates and clear requests are simply not looked at then.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = cnt_q;
         mem_wdata = '0;
         busy_d    = '0;
         cnt_d     = cnt_q + 1'b1;
         if (cnt_q == LAST_ENTRY) begin
            state_d = ST_IDLE;
         end
      end else begin
         mem_we = wr_en && !wr_to_zero;
         if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
         end
         // A new producer issued in the same cycle as an older writeback keeps the register busy.
         if (sb_set_en && !set_to_zero) begin
            busy_d[sb_set_addr] = 1'b1;
         end
         if (clr_req) begin
            busy_d  = '0;
            cnt_d   = '0;
            state_d = ST_CLEAR;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         busy_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign ra = rd_addr[k*ADDR_W +: ADDR_W];

      // A hardwired-zero entry beats the bypass, which in turn hides a stale busy bit.
      always_comb begin
         data = mem_q[ra];
         busy = busy_q[ra];
         if ((ZERO_REG != 0) && (ra == '0)) begin
            data = '0;
            busy = 1'b0;
         end else if ((BYPASS != 0) && idle && wr_en && (wr_addr == ra)) begin
            data = wr_data;
            busy = 1'b0;
         end
      end

      assign rd_data[k*DATA_W +: DATA_W] = data;
      assign rd_busy[k]                  = busy;
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: a default instance, a no-bypass twin sharing its
// inputs, and a wide 4-port instance, checked by vector tables and a behavioural model.
module tb_regfile_mp_sb;

   localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
   localparam int WDW = 64, WAW = 4, WNR = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DW-1:0]     wr_data;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*DW-1:0]  rd_data, nb_rd_data;
   logic [NR-1:0]     rd_busy, nb_rd_busy;
   logic              sb_set_en;
   logic [AW-1:0]     sb_set_addr;
   logic              clr_req;
   logic              clr_busy, nb_clr_busy;

   logic              w_wr_en;
   logic [WAW-1:0]    w_wr_addr;
   logic [WDW-1:0]    w_wr_data;
   logic [WNR*WAW-1:0] w_rd_addr;
   logic [WNR*WDW-1:0] w_rd_data;
   logic [WNR-1:0]    w_rd_busy;
   logic              w_sb_set_en;
   logic [WAW-1:0]    w_sb_set_addr;
   logic              w_clr_req;
   logic              w_clr_busy;

   regfile_mp_sb dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .sb_set_en(sb_set_en),
      .sb_set_addr(sb_set_addr), .clr_req(clr_req), .clr_busy(clr_busy)
   );

   regfile_mp_sb #(.BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy), .sb_set_en(sb_set_en),
      .sb_set_addr(sb_set_addr), .clr_req(clr_req), .clr_busy(nb_clr_busy)
   );

   regfile_mp_sb #(.DATA_W(WDW), .ADDR_W(WAW), .NUM_RD(WNR), .ZERO_REG(0)) dut_w (
      .clk(clk), .reset(reset), .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
      .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy), .sb_set_en(w_sb_set_en),
      .sb_set_addr(w_sb_set_addr), .clr_req(w_clr_req), .clr_busy(w_clr_busy)
   );

   // Reference model: register contents, which entries hold known values, busy flags,
   // and how far a running clear has progressed.
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_valid [DEPTH];
   bit            m_busy [DEPTH];
   bit            m_clearing;
   int            m_clr_idx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          we;
      int          wa;
      logic [31:0] wd;
      int          ra0;
      int          ra1;
      int          sbe;
      int          sba;
      logic [31:0] d0;
      int          b0;
      logic [31:0] d1;
      int          b1;
   } vec_t;

   vec_t vecs [11];

   function automatic void model_reset();
      m_clearing = 1'b1;
      m_clr_idx  = 0;
      for (int i = 0; i < DEPTH; i++) begin
         m_busy[i]  = 1'b0;
         m_valid[i] = 1'b0;
      end
   endfunction

   function automatic void model_step();
      if (m_clearing) begin
         m_mem[m_clr_idx]   = '0;
         m_valid[m_clr_idx] = 1'b1;
         m_clr_idx++;
         if (m_clr_idx == DEPTH) m_clearing = 1'b0;
      end else begin
         if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr]   = wr_data;
            m_valid[wr_addr] = 1'b1;
         end
         if (wr_en) m_busy[wr_addr] = 1'b0;
         if (sb_set_en && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
         if (clr_req) begin
            m_clearing = 1'b1;
            m_clr_idx  = 0;
            for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
         end
      end
   endfunction

   function automatic void model_read(input logic [AW-1:0] a, input bit byp,
                                      output logic [DW-1:0] d, output bit b, output bit known);
      known = 1'b1;
      b     = 1'b0;
      if (a == 0) begin
         d = '0;
      end else if (byp && !m_clearing && wr_en && wr_addr == a) begin
         d = wr_data;
      end else begin
         d     = m_mem[a];
         b     = m_busy[a];
         known = m_valid[a];
      end
   endfunction

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic apply_stimulus(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                                 input bit sbe, input logic [AW-1:0] sba, input bit clr);
      wr_en       = we;
      wr_addr     = wa;
      wr_data     = wd;
      rd_addr     = {ra1, ra0};
      sb_set_en   = sbe;
      sb_set_addr = sba;
      clr_req     = clr;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag);
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      bit            eb, known;
      for (int p = 0; p < NR; p++) begin
         a = rd_addr[p*AW +: AW];
         model_read(a, 1'b1, ed, eb, known);
         if (known) check($sformatf("%s data p%0d r%0d", tag, p, a), 64'(rd_data[p*DW +: DW]), 64'(ed));
         check($sformatf("%s busy p%0d r%0d", tag, p, a), 64'(rd_busy[p]), 64'(eb));
         model_read(a, 1'b0, ed, eb, known);
         if (known) check($sformatf("%s nobyp data p%0d r%0d", tag, p, a), 64'(nb_rd_data[p*DW +: DW]), 64'(ed));
         check($sformatf("%s nobyp busy p%0d r%0d", tag, p, a), 64'(nb_rd_busy[p]), 64'(eb));
      end
      check($sformatf("%s clr_busy", tag), 64'(clr_busy), 64'(m_clearing));
      check($sformatf("%s nobyp clr_busy", tag), 64'(nb_clr_busy), 64'(m_clearing));
   endtask

   // Counts cycles of clr_busy on the main and wide instances until both are idle.
   task automatic run_clear(input string tag, output int n, output int nw);
      n  = 0;
      nw = 0;
      for (int i = 0; i < 100; i++) begin
         check_output(tag);
         if (!clr_busy && !w_clr_busy) break;
         if (clr_busy) n++;
         if (w_clr_busy) nw++;
         step();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n, nw;

      vecs[0]  = '{1, 5, 32'h12345678, 5, 0, 0, 0, 32'h12345678, 0, 32'h0, 0};
      vecs[1]  = '{1, 0, 32'hFFFFFFFF, 5, 0, 0, 0, 32'h12345678, 0, 32'h0, 0};
      vecs[2]  = '{0, 0, 32'h0,        9, 0, 1, 9, 32'h0,        0, 32'h0, 0};
      vecs[3]  = '{0, 0, 32'h0,        9, 9, 0, 0, 32'h0,        1, 32'h0, 1};
      vecs[4]  = '{1, 9, 32'h55,       9, 5, 0, 0, 32'h55,       0, 32'h12345678, 0};
      vecs[5]  = '{0, 0, 32'h0,        9, 9, 0, 0, 32'h55,       0, 32'h55, 0};
      vecs[6]  = '{1, 9, 32'h66,       9, 7, 1, 9, 32'h66,       0, 32'h0, 0};
      vecs[7]  = '{0, 0, 32'h0,        9, 7, 0, 0, 32'h66,       1, 32'h0, 0};
      vecs[8]  = '{1, 7, 32'hA5A5A5A5, 7, 9, 0, 0, 32'hA5A5A5A5, 0, 32'h66, 1};
      vecs[9]  = '{0, 0, 32'h0,        0, 7, 1, 0, 32'h0,        0, 32'hA5A5A5A5, 0};
      vecs[10] = '{0, 0, 32'h0,        0, 7, 0, 0, 32'h0,        0, 32'hA5A5A5A5, 0};

      reset = 1'b0;
      apply_stimulus(1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
      w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr = '0;
      w_sb_set_en = 1'b0; w_sb_set_addr = '0; w_clr_req = 1'b0;
      model_reset();

      #12;
      check("reset clr_busy", 64'(clr_busy), 64'd1);
      check("reset wide clr_busy", 64'(w_clr_busy), 64'd1);
      check("reset rd_busy", 64'(rd_busy), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      $display("[TB] reset release, clear with write held");
      run_clear("init clear", n, nw);
      check("init clear length", 64'(n), 64'd32);
      check("init wide clear length", 64'(nw), 64'd16);
      wr_en = 1'b0;
      #1;
      check("r3 after clear", 64'(rd_data[0 +: DW]), 64'd0);
      check("r3 nobyp after clear", 64'(nb_rd_data[0 +: DW]), 64'd0);

      $display("[TB] directed vector table");
      for (int i = 0; i < 11; i++) begin
         apply_stimulus(vecs[i].we[0], vecs[i].wa[4:0], vecs[i].wd, vecs[i].ra0[4:0],
                        vecs[i].ra1[4:0], vecs[i].sbe[0], vecs[i].sba[4:0], 1'b0);
         #1;
         check($sformatf("vec%0d d0", i), 64'(rd_data[0 +: DW]), 64'(vecs[i].d0));
         check($sformatf("vec%0d b0", i), 64'(rd_busy[0]), 64'(vecs[i].b0));
         check($sformatf("vec%0d d1", i), 64'(rd_data[DW +: DW]), 64'(vecs[i].d1));
         check($sformatf("vec%0d b1", i), 64'(rd_busy[1]), 64'(vecs[i].b1));
         check_output($sformatf("vec%0d", i));
         step();
      end

      $display("[TB] clear request with pending busy and blocked writes");
      apply_stimulus(1'b1, 5'd1, 32'h11, 5'd1, 5'd4, 1'b0, 5'd0, 1'b0);
      step();
      apply_stimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd4, 1'b1, 5'd4, 1'b0);
      step();
      apply_stimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd4, 1'b0, 5'd0, 1'b0);
      #1;
      check("r1 before clear", 64'(rd_data[0 +: DW]), 64'h11);
      check("r4 busy before clear", 64'(rd_busy[1]), 64'd1);
      clr_req = 1'b1;
      step();
      apply_stimulus(1'b1, 5'd1, 32'h99, 5'd1, 5'd4, 1'b1, 5'd4, 1'b0);
      run_clear("req clear", n, nw);
      check("req clear length", 64'(n), 64'd32);
      apply_stimulus(1'b0, 5'd0, 32'h0, 5'd1, 5'd4, 1'b0, 5'd0, 1'b0);
      #1;
      check("r1 after req clear", 64'(rd_data[0 +: DW]), 64'd0);
      check("r4 busy after req clear", 64'(rd_busy[1]), 64'd0);

      $display("[TB] reset during clear");
      apply_stimulus(1'b0, 5'd0, 32'h0, 5'd2, 5'd6, 1'b0, 5'd0, 1'b1);
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_output("pre-abort clear");
         step();
      end
      reset = 1'b0;
      model_reset();
      #2;
      check("abort clr_busy", 64'(clr_busy), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      run_clear("restart clear", n, nw);
      check("restart clear length", 64'(n), 64'd32);
      check("restart wide clear length", 64'(nw), 64'd16);

      $display("[TB] wide 4-port instance");
      w_wr_en = 1'b1;
      w_wr_addr = 4'd0; w_wr_data = 64'hCAFE;                step();
      w_wr_addr = 4'd1; w_wr_data = 64'h1111_2222_3333_4444; step();
      w_wr_addr = 4'd2; w_wr_data = 64'h5555_6666_7777_8888; step();
      w_wr_addr = 4'd3; w_wr_data = 64'h9999_AAAA_BBBB_CCCC; step();
      w_wr_en = 1'b0;
      w_rd_addr = {4'd0, 4'd1, 4'd2, 4'd3};
      #1;
      check("wide p0 r3", w_rd_data[0*WDW +: WDW], 64'h9999_AAAA_BBBB_CCCC);
      check("wide p1 r2", w_rd_data[1*WDW +: WDW], 64'h5555_6666_7777_8888);
      check("wide p2 r1", w_rd_data[2*WDW +: WDW], 64'h1111_2222_3333_4444);
      check("wide p3 r0", w_rd_data[3*WDW +: WDW], 64'hCAFE);
      check("wide busy idle", 64'(w_rd_busy), 64'd0);
      w_sb_set_en = 1'b1;
      w_sb_set_addr = 4'd0;
      step();
      w_sb_set_en = 1'b0;
      #1;
      check("wide r0 busy", 64'(w_rd_busy), 64'b1000);

      $display("[TB] randomized traffic against model");
      for (int i = 0; i < 400; i++) begin
         apply_stimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom(),
                        5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                        ($urandom_range(0, 99) == 0));
         #1;
         check_output($sformatf("rand%0d", i));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
